// File: rtl/tdm_demux_4.sv
`default_nettype none
// ============================================================================
// tdm_demux_4 : four-slot TDM demultiplexer; slot 0..3 -> lanes A..D,
//               each complete frame applied atomically with a one-cycle strobe.
// Revision    : 1.0
// ============================================================================
module tdm_demux_4 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sof,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] D,
   output logic [1:0]       sel,
   output logic             frame_valid,
   output logic             sync_err
);

   typedef enum logic [0:0] {
      HUNT = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
   logic             fv_q, fv_d, se_q, se_d;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      s0_d    = s0_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      fv_d    = 1'b0;
      se_d    = 1'b0;

      if (din_valid) begin
         if (sof) begin
            // An sof while filling abandons the partial frame; the word restarts slot 0.
            se_d    = (state_q == FILL);
            s0_d    = din;
            sel_d   = 2'd1;
            state_d = FILL;
         end else if (state_q == HUNT) begin
            se_d = 1'b1;
         end else begin
            case (sel_q)
               2'd1: begin
                  s1_d  = din;
                  sel_d = 2'd2;
               end
               2'd2: begin
                  s2_d  = din;
                  sel_d = 2'd3;
               end
               2'd3: begin
                  a_d     = s0_q;
                  b_d     = s1_q;
                  c_d     = s2_q;
                  d_d     = din;
                  fv_d    = 1'b1;
                  sel_d   = 2'd0;
                  state_d = HUNT;
               end
               default: begin
                  sel_d = sel_q;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
         sel_q   <= 2'd0;
         s0_q    <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         fv_q    <= 1'b0;
         se_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         fv_q    <= fv_d;
         se_q    <= se_d;
      end
   end

   assign A           = a_q;
   assign B           = b_q;
   assign C           = c_q;
   assign D           = d_q;
   assign sel         = sel_q;
   assign frame_valid = fv_q;
   assign sync_err    = se_q;

endmodule
`default_nettype wire
